// File: rtl/call_stack_pkg.sv
// Shared defaults and microcode bit positions for the call stack and the control unit.
// Also holds the push/pop strobe decode used by the stack's pointer logic.
package call_stack_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int FLAGS_W_DEF    = 4;
  localparam int DEPTH_DEF      = 8;
  localparam int PUSH_STACK_BIT = 16;
  localparam int POP_STACK_BIT  = 17;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/call_stack_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
// Latency: write lands at the clock edge, read is combinational; no backpressure.
module stack_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address/flags stack serving CU push/pop strobes; top-of-stack is zero-latency.
// Never stalls: push while full and pop while empty are dropped and flagged sticky.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int FLAGS_W = FLAGS_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_push_en,
  input  logic                       in_pop_en,
  input  logic [ADDR_W-1:0]          in_push_addr,
  input  logic [FLAGS_W-1:0]         in_push_flags,
  output logic [ADDR_W-1:0]          out_pop_addr,
  output logic [FLAGS_W-1:0]         out_stack_flags,
  output logic [$clog2(DEPTH):0]     out_depth,
  output logic                       out_full,
  output logic                       out_empty,
  output logic                       out_overflow,
  output logic                       out_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = FLAGS_W + ADDR_W;

  logic [CNT_W-1:0] r_depth;
  logic             r_overflow;
  logic             r_underflow;

  stack_op_e        w_op;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic [PTR_W-1:0] w_waddr;
  logic [PTR_W-1:0] w_raddr;
  logic [ENT_W-1:0] w_rdata;

  assign w_op    = decode_op(in_push_en, in_pop_en);
  assign w_empty = (r_depth == '0);
  assign w_full  = (r_depth == CNT_W'(DEPTH));
  // Top index wraps to DEPTH-1 when empty; the read is masked to zero in that case.
  assign w_raddr = r_depth[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_depth[PTR_W-1:0];
    if (!rst) begin
      case (w_op)
        OP_PUSH: w_we = !w_full;
        OP_REPLACE: begin
          w_we = 1'b1;
          if (!w_empty) w_waddr = w_raddr;
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          if (w_full) r_overflow <= 1'b1;
          else        r_depth    <= r_depth + CNT_W'(1);
        end
        OP_POP: begin
          if (w_empty) r_underflow <= 1'b1;
          else         r_depth     <= r_depth - CNT_W'(1);
        end
        OP_REPLACE: begin
          // Replace-top on an empty stack degrades to a plain push.
          if (w_empty) begin
            r_depth     <= CNT_W'(1);
            r_underflow <= 1'b1;
          end
        end
        default: r_depth <= r_depth;
      endcase
    end
  end

  stack_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({in_push_flags, in_push_addr}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign {out_stack_flags, out_pop_addr} = w_empty ? '0 : w_rdata;
  assign out_depth     = r_depth;
  assign out_full      = w_full;
  assign out_empty     = w_empty;
  assign out_overflow  = r_overflow;
  assign out_underflow = r_underflow;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: queue-based reference model checked every negedge,
// plus directed sequences with hand-computed literal expectations.
module tb_call_stack;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_push_en;
  logic       in_pop_en;
  logic [7:0] in_push_addr;
  logic [3:0] in_push_flags;
  logic [7:0] out_pop_addr;
  logic [3:0] out_stack_flags;
  logic [3:0] out_depth;
  logic       out_full;
  logic       out_empty;
  logic       out_overflow;
  logic       out_underflow;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [11:0] mq[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  always #5 clk = ~clk;

  call_stack dut (
    .clk             (clk),
    .rst             (rst),
    .in_push_en      (in_push_en),
    .in_pop_en       (in_pop_en),
    .in_push_addr    (in_push_addr),
    .in_push_flags   (in_push_flags),
    .out_pop_addr    (out_pop_addr),
    .out_stack_flags (out_stack_flags),
    .out_depth       (out_depth),
    .out_full        (out_full),
    .out_empty       (out_empty),
    .out_overflow    (out_overflow),
    .out_underflow   (out_underflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stack as a queue, back is the top.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (in_push_en && in_pop_en) begin
      if (mq.size() == 0) begin
        mq.push_back({in_push_flags, in_push_addr});
        m_unf = 1'b1;
      end else begin
        mq[mq.size()-1] = {in_push_flags, in_push_addr};
      end
    end else if (in_push_en) begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back({in_push_flags, in_push_addr});
    end else if (in_pop_en) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] top;
      top = (mq.size() == 0) ? 12'h000 : mq[mq.size()-1];
      chk("m_depth", out_depth, mq.size());
      chk("m_full", out_full, mq.size() == DEPTH);
      chk("m_empty", out_empty, mq.size() == 0);
      chk("m_addr", out_pop_addr, top[7:0]);
      chk("m_flags", out_stack_flags, top[11:8]);
      chk("m_ovf", out_overflow, m_ovf);
      chk("m_unf", out_underflow, m_unf);
    end
  end

  task automatic drive(input logic r, input logic pu, input logic po,
                       input logic [7:0] a, input logic [3:0] f);
    @(posedge clk);
    #1;
    rst           = r;
    in_push_en    = pu;
    in_pop_en     = po;
    in_push_addr  = a;
    in_push_flags = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    rst = 1'b1; in_push_en = 1'b0; in_pop_en = 1'b0;
    in_push_addr = 8'h00; in_push_flags = 4'h0;

    // 1: reset then idle
    @(posedge clk);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
    repeat (3) idle();
    #1;
    chk("rst_depth", out_depth, 0);
    chk("rst_empty", out_empty, 1);
    chk("rst_full", out_full, 0);
    chk("rst_addr", out_pop_addr, 0);
    chk("rst_ovf_unf", {out_overflow, out_underflow}, 0);

    // 2: two pushes, two pops
    drive(1'b0, 1'b1, 1'b0, 8'h12, 4'h1);
    drive(1'b0, 1'b1, 1'b0, 8'h34, 4'h2);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
    #1;
    chk("pop1_addr", out_pop_addr, 8'h34);
    chk("pop1_flags", out_stack_flags, 4'h2);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
    #1;
    chk("pop2_addr", out_pop_addr, 8'h12);
    chk("pop2_flags", out_stack_flags, 4'h1);
    idle();
    #1;
    chk("t2_empty", out_empty, 1);
    chk("t2_unf", out_underflow, 0);

    // 3: fill, replace-top while full, overflow, drain
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 8'(i), 4'(i));
    idle();
    #1;
    chk("t3_full", out_full, 1);
    chk("t3_ovf0", out_overflow, 0);
    drive(1'b0, 1'b1, 1'b1, 8'h07, 4'h9);
    #1;
    chk("t3_rep_old_flags", out_stack_flags, 4'h7);
    idle();
    #1;
    chk("t3_rep_flags", out_stack_flags, 4'h9);
    chk("t3_rep_depth", out_depth, 8);
    chk("t3_rep_no_ovf", out_overflow, 0);
    drive(1'b0, 1'b1, 1'b0, 8'h08, 4'h8);
    idle();
    #1;
    chk("t3_ovf1", out_overflow, 1);
    chk("t3_top", out_pop_addr, 8'h07);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
      #1;
      chk("t3_pop_seq", out_pop_addr, 8'(i));
    end
    idle();
    #1;
    chk("t3_empty", out_empty, 1);

    // 4: underflow then push
    drive(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
    idle();
    #1;
    chk("t4_unf", out_underflow, 1);
    chk("t4_depth0", out_depth, 0);
    chk("t4_addr0", out_pop_addr, 0);
    drive(1'b0, 1'b1, 1'b0, 8'h55, 4'h5);
    idle();
    #1;
    chk("t4_depth1", out_depth, 1);
    chk("t4_unf_sticky", out_underflow, 1);

    // 5: push then replace-top
    drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 8'hA0, 4'h0);
    drive(1'b0, 1'b1, 1'b1, 8'hB1, 4'h3);
    #1;
    chk("t5_old_top", out_pop_addr, 8'hA0);
    idle();
    #1;
    chk("t5_new_addr", out_pop_addr, 8'hB1);
    chk("t5_new_flags", out_stack_flags, 4'h3);
    chk("t5_depth", out_depth, 1);

    // push+pop on empty acts as a push and flags underflow
    drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
    drive(1'b0, 1'b1, 1'b1, 8'hC2, 4'h4);
    idle();
    #1;
    chk("pp_empty_depth", out_depth, 1);
    chk("pp_empty_addr", out_pop_addr, 8'hC2);
    chk("pp_empty_unf", out_underflow, 1);

    // 6: reset wins over a concurrent push
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), 4'h1);
    drive(1'b1, 1'b1, 1'b0, 8'h99, 4'h9);
    #1;
    chk("t6_depth3", out_depth, 3);
    idle();
    #1;
    chk("t6_depth0", out_depth, 0);
    chk("t6_empty", out_empty, 1);
    chk("t6_unf_clr", out_underflow, 0);
    chk("t6_ovf_clr", out_overflow, 0);

    repeat (2) idle();
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
